tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_pkg.sv | 11 +
 rtl/tdm_demux4_if.sv | 30 +++
 rtl/tdm_slot_ctr.sv | 23 ++
 rtl/tdm_demux4.sv | 121 ++++++++++++
 tb/tb_tdm_demux4.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared constants for the 4-slot TDM demultiplexer.
// Slot geometry and the frame-alignment state encoding.
package tdm_demux4_pkg;

  localparam int NSLOTS = 4;
  localparam int SLOT_W = 2;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

endpackage

// File: rtl/tdm_demux4_if.sv
// Slot-data bus into the demux and frame bus out of it.
// Master drives samples; slave returns decoded frames.
interface tdm_demux4_if #(
  parameter int W = 1
);
  import tdm_demux4_pkg::*;

  logic [W-1:0]      din;
  logic              en;
  logic              sync;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [W-1:0]      c;
  logic [W-1:0]      d;
  logic              valid;
  logic [SLOT_W-1:0] slot;
  logic              locked;
  logic              err;

  modport master (
    output din, en, sync,
    input  a, b, c, d, valid, slot, locked, err
  );

  modport slave (
    input  din, en, sync,
    output a, b, c, d, valid, slot, locked, err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Mod-4 slot index counter.
// A load (sync sample) always points at slot 1 next.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with sync-based frame lock.
// Frames are gathered in shadows and published on the last slot.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  logic [0:0]        state_q, state_d;
  logic [W-1:0]      sh0_q, sh0_d;
  logic [W-1:0]      sh1_q, sh1_d;
  logic [W-1:0]      sh2_q, sh2_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      c_q, c_d;
  logic [W-1:0]      d_q, d_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              cnt_inc;
  logic              cnt_load;
  logic [SLOT_W-1:0] slot;

  tdm_slot_ctr u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_inc),
    .load (cnt_load),
    .slot (slot)
  );

  always_comb begin
    state_d  = state_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    cnt_load = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            state_d  = LOCKED;
            sh0_d    = bus.din;
            cnt_load = 1'b1;
          end
        end
        LOCKED: begin
          // Sync away from slot 0 restarts the frame.
          if (bus.sync) begin
            err_d    = (slot != '0);
            sh0_d    = bus.din;
            cnt_load = 1'b1;
          end else if (slot == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            cnt_inc = 1'b1;
            unique case (slot)
              2'd1: sh1_d = bus.din;
              2'd2: sh2_d = bus.din;
              default: begin
                a_d     = sh0_q;
                b_d     = sh1_q;
                c_d     = sh2_q;
                d_d     = bus.din;
                valid_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.c      = c_q;
  assign bus.d      = d_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.slot   = slot;
  assign bus.locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frames plus random traffic
// checked against a queue-based frame model.
module tb_tdm_demux4;
  localparam int W = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcyc   = -100;
  int vgap   = 0;
  int nvalid = 0;

  bit m_lock;
  int m_q[$];
  int m_o[4];
  bit m_v;
  bit m_e;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_lock = 1'b0;
    m_q.delete();
    for (int i = 0; i < 4; i++) m_o[i] = 0;
    m_v = 1'b0;
    m_e = 1'b0;
  endtask

  task automatic check_all();
    check("a", 32'(bus.a), 32'(m_o[0]));
    check("b", 32'(bus.b), 32'(m_o[1]));
    check("c", 32'(bus.c), 32'(m_o[2]));
    check("d", 32'(bus.d), 32'(m_o[3]));
    check("valid", 32'(bus.valid), 32'(m_v));
    check("err", 32'(bus.err), 32'(m_e));
    check("locked", 32'(bus.locked), 32'(m_lock));
    check("slot", 32'(bus.slot), 32'(m_q.size()));
    check("excl", 32'(bus.valid & bus.err), 32'(0));
  endtask

  // Frame-level model: a frame is the list of samples since sync.
  task automatic model(bit e, bit s, int d);
    m_v = 1'b0;
    m_e = 1'b0;
    if (e) begin
      if (!m_lock) begin
        if (s) begin
          m_lock = 1'b1;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s) begin
        if (m_q.size() != 0) m_e = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_e    = 1'b1;
        m_lock = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_o[i] = m_q[i];
          m_v = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic step(bit e, bit s, int d);
    @(negedge clk);
    bus.en   = e;
    bus.sync = s;
    bus.din  = W'(d);
    @(posedge clk);
    cyc++;
    model(e, s, d);
    #1;
    check_all();
    if (bus.valid) begin
      nvalid++;
      vgap = cyc - vcyc;
      vcyc = cyc;
    end
  endtask

  task automatic frame(int v0, int v1, int v2, int v3);
    step(1, 1, v0);
    step(1, 0, v1);
    step(1, 0, v2);
    step(1, 0, v3);
  endtask

  task automatic gap3();
    for (int i = 0; i < 3; i++) step(0, 0, int'($urandom_range(0, 1)));
  endtask

  int nv0;

  initial begin
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.din  = '0;
    m_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    #11 rst_n = 1'b1;

    // Single frame 1,0,1,0
    frame(1, 0, 1, 0);
    check("f1_valid", 32'(bus.valid), 32'(1));
    check("f1_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h0a);

    // Back-to-back frames
    frame(0, 1, 1, 0);
    check("b2b_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h06);
    check("b2b_gap", 32'(vgap), 32'(4));

    // Gapped frame 1,1,0,1
    nv0 = nvalid;
    step(1, 1, 1);
    gap3();
    check("gap_slot", 32'(bus.slot), 32'(1));
    step(1, 0, 1);
    gap3();
    step(1, 0, 0);
    gap3();
    step(1, 0, 1);
    check("gap_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h0d);
    check("gap_nvalid", 32'(nvalid - nv0), 32'(1));

    // Misplaced sync at slot 2
    step(1, 1, 1);
    step(1, 0, 0);
    check("rs_slot2", 32'(bus.slot), 32'(2));
    step(1, 1, 1);
    check("rs_err", 32'(bus.err), 32'(1));
    check("rs_valid", 32'(bus.valid), 32'(0));
    check("rs_slot", 32'(bus.slot), 32'(1));
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    check("rs_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h0b);
    frame(0, 1, 0, 0);
    check("rs_next", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h04);

    // Missing sync at slot 0 drops lock
    step(1, 0, 1);
    check("ul_err", 32'(bus.err), 32'(1));
    check("ul_locked", 32'(bus.locked), 32'(0));
    for (int i = 0; i < 5; i++) step(1, 0, int'($urandom_range(0, 1)));
    check("ul_hold", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h04);
    frame(1, 1, 1, 1);

    // Async reset after two samples
    step(1, 1, 0);
    step(1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h0);
    check("rst_locked", 32'(bus.locked), 32'(0));
    check("rst_slot", 32'(bus.slot), 32'(0));
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1);
    step(1, 0, 0);
    frame(0, 1, 1, 0);
    check("post_rst", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'h06);

    // Random traffic, sync mostly aligned
    for (int i = 0; i < 400; i++) begin
      bit e;
      bit s;
      e = ($urandom % 4) != 0;
      if (!m_lock) s = ($urandom % 3) == 0;
      else if (m_q.size() == 0) s = ($urandom % 8) != 0;
      else s = ($urandom % 12) == 0;
      step(e, s, int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
